// File: rtl/button_event_ctrl.sv
// rtl/button_event_ctrl.sv - debounced multi-button press/release/long-press event queue
module button_event_ctrl #(
    parameter int NUM_BTN         = 2,
    parameter bit ACTIVE_HIGH     = 1'b1,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic               evt_valid,
    output logic [4:0]         evt_code,
    input  logic               evt_rd,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic [NUM_BTN-1:0] btn_state
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_state;
    logic [DB_W-1:0]    r_db_cnt   [NUM_BTN];
    logic [HOLD_W-1:0]  r_hold_cnt [NUM_BTN];
    logic [NUM_BTN-1:0] w_flip;
    logic [NUM_BTN-1:0] w_ev_press;
    logic [NUM_BTN-1:0] w_ev_rel;
    logic [NUM_BTN-1:0] w_ev_long;
    logic [NUM_BTN-1:0] r_pend_press;
    logic [NUM_BTN-1:0] r_pend_long;
    logic [NUM_BTN-1:0] r_pend_rel;
    logic [NUM_BTN-1:0] w_sel_press;
    logic [NUM_BTN-1:0] w_sel_long;
    logic [NUM_BTN-1:0] w_sel_rel;
    logic [NUM_BTN-1:0] w_coll;
    logic               w_arb_valid;
    logic [4:0]         w_arb_code;
    logic [PTR_W:0]     r_wr_ptr;
    logic [PTR_W:0]     r_wr_ptr_q;
    logic [PTR_W:0]     r_rd_ptr;
    logic [4:0]         r_mem [FIFO_DEPTH];
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               r_overflow;

    assign w_level = ACTIVE_HIGH ? btn_in : ~btn_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_level;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_flip    = '0;
        w_ev_long = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            w_flip[i]    = (r_sync2[i] != r_state[i]) && (r_db_cnt[i] == DB_LAST);
            w_ev_long[i] = r_state[i] && (r_hold_cnt[i] == HOLD_PRE);
        end
    end

    assign w_ev_press = w_flip & ~r_state;
    assign w_ev_rel   = w_flip & r_state;

    // Hold counter saturates at its last value so a long press fires once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                r_db_cnt[i]   <= '0;
                r_hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (r_sync2[i] == r_state[i] || w_flip[i])
                    r_db_cnt[i] <= '0;
                else
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                if (w_flip[i])
                    r_state[i] <= ~r_state[i];
                if (w_ev_press[i])
                    r_hold_cnt[i] <= '0;
                else if (r_state[i] && r_hold_cnt[i] != HOLD_LAST)
                    r_hold_cnt[i] <= r_hold_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        w_arb_valid = 1'b0;
        w_arb_code  = '0;
        w_sel_press = '0;
        w_sel_long  = '0;
        w_sel_rel   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (r_pend_press[i] || r_pend_long[i] || r_pend_rel[i]) begin
                w_arb_valid = 1'b1;
                w_sel_press = '0;
                w_sel_long  = '0;
                w_sel_rel   = '0;
                if (r_pend_press[i]) begin
                    w_sel_press[i] = 1'b1;
                    w_arb_code     = {2'b01, 3'(i)};
                end else if (r_pend_long[i]) begin
                    w_sel_long[i] = 1'b1;
                    w_arb_code    = {2'b11, 3'(i)};
                end else begin
                    w_sel_rel[i] = 1'b1;
                    w_arb_code   = {2'b10, 3'(i)};
                end
            end
        end
    end

    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push  = w_arb_valid && !w_full;
    assign w_coll  = (w_ev_press & r_pend_press) | (w_ev_long & r_pend_long) |
                     (w_ev_rel & r_pend_rel);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_press <= '0;
            r_pend_long  <= '0;
            r_pend_rel   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pend_press <= (r_pend_press & ~(w_sel_press & {NUM_BTN{w_push}})) |
                            (w_ev_press & ~r_pend_press);
            r_pend_long  <= (r_pend_long & ~(w_sel_long & {NUM_BTN{w_push}})) |
                            (w_ev_long & ~r_pend_long);
            r_pend_rel   <= (r_pend_rel & ~(w_sel_rel & {NUM_BTN{w_push}})) |
                            (w_ev_rel & ~r_pend_rel);
            if (|w_coll)
                r_overflow <= 1'b1;
            else if (ovf_clr)
                r_overflow <= 1'b0;
        end
    end

    // Read side sees the write pointer one cycle late, so a new entry becomes
    // visible the cycle after it is written; popping stays safe against it.
    assign w_empty = (r_rd_ptr == r_wr_ptr_q);
    assign w_pop   = evt_rd && !w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_wr_ptr_q <= '0;
            r_rd_ptr   <= '0;
            for (int j = 0; j < FIFO_DEPTH; j++)
                r_mem[j] <= '0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr;
            if (w_push) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= w_arb_code;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign evt_valid = !w_empty;
    assign evt_code  = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign overflow  = r_overflow;
    assign btn_state = r_state;

endmodule

// File: tb/tb_button_event_ctrl.sv
// tb/tb_button_event_ctrl.sv - randomized and directed bench for button_event_ctrl
module tb_button_event_ctrl;
    localparam int NB    = 2;
    localparam int DEB   = 4;
    localparam int LNG   = 20;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic          evt_rd = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          evt_valid;
    logic [4:0]    evt_code;
    logic          overflow;
    logic [NB-1:0] btn_state;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: pin history, debounced levels, pending events, queue.
    int            t;
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_state;
    int            last_flip [NB];
    int            press_edge [NB];
    bit            pp [NB];
    bit            pl [NB];
    bit            pr [NB];
    logic [4:0]    mq[$];
    int            vis;
    bit            m_ovf;
    bit            m_valid;
    logic [4:0]    m_code;

    button_event_ctrl #(
        .NUM_BTN(NB), .ACTIVE_HIGH(1'b1), .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LNG), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_rd(evt_rd), .overflow(overflow),
        .ovf_clr(ovf_clr), .btn_state(btn_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        mq.delete();
        t = 0;
        m_state = '0;
        vis = 0;
        m_ovf = 1'b0;
        m_valid = 1'b0;
        m_code = '0;
        for (int i = 0; i < NB; i++) begin
            last_flip[i] = -1;
            press_edge[i] = -1000;
            pp[i] = 1'b0;
            pl[i] = 1'b0;
            pr[i] = 1'b0;
        end
    endtask

    task automatic step();
        logic [NB-1:0] st_new;
        bit evp [NB];
        bit evl [NB];
        bit evr [NB];
        int sel;
        int size_before;
        bit push;
        bit pop;
        bit coll;
        logic [4:0] code;
        @(posedge clk);
        hist.push_back(btn_in);
        st_new = m_state;
        for (int i = 0; i < NB; i++) begin
            bit flip;
            flip = (t - last_flip[i]) >= DEB;
            for (int k = t - DEB + 1; k <= t; k++) begin
                logic [NB-1:0] h;
                h = '0;
                if (k >= 2) h = hist[k-2];
                if (h[i] == m_state[i]) flip = 1'b0;
            end
            evp[i] = flip && !m_state[i];
            evr[i] = flip && m_state[i];
            evl[i] = m_state[i] && (t - press_edge[i] == LNG - 1);
            if (flip) begin
                st_new[i] = !m_state[i];
                last_flip[i] = t;
            end
            if (evp[i]) press_edge[i] = t;
        end
        sel = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (pp[i] || pl[i] || pr[i]) sel = i;
        code = '0;
        if (sel >= 0)
            code = pp[sel] ? {2'b01, 3'(sel)} : pl[sel] ? {2'b11, 3'(sel)} : {2'b10, 3'(sel)};
        size_before = mq.size();
        push = (sel >= 0) && (size_before < DEPTH);
        pop = evt_rd && (vis > 0);
        coll = 1'b0;
        for (int i = 0; i < NB; i++) begin
            bit cp, cl, cr;
            cp = push && sel == i && pp[i];
            cl = push && sel == i && !pp[i] && pl[i];
            cr = push && sel == i && !pp[i] && !pl[i];
            if ((evp[i] && pp[i]) || (evl[i] && pl[i]) || (evr[i] && pr[i])) coll = 1'b1;
            pp[i] = (evp[i] && !pp[i]) || (pp[i] && !cp);
            pl[i] = (evl[i] && !pl[i]) || (pl[i] && !cl);
            pr[i] = (evr[i] && !pr[i]) || (pr[i] && !cr);
        end
        m_ovf = coll ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        if (pop) void'(mq.pop_front());
        vis = size_before - (pop ? 1 : 0);
        if (push) mq.push_back(code);
        m_state = st_new;
        m_valid = vis > 0;
        m_code = m_valid ? mq[0] : 5'b0;
        t++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        evt_rd = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        btn_in = '0;
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (btn_state !== '0) begin n_fail++; $display("FAIL reset_btn_state got=%b exp=0", btn_state); end
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid got=%b exp=0", evt_valid); end
        n_checks++;
        if (evt_code !== 5'b0) begin n_fail++; $display("FAIL reset_evt_code got=%b exp=0", evt_code); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        do_reset();
    endtask

    task automatic test_single_press();
        btn_in[0] = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL single_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
            if (c == 5 || c == 6) begin
                n_checks++;
                if (btn_state[0] !== (c == 6)) begin n_fail++; $display("FAIL single_latency c=%0d got=%b exp=%b", c, btn_state[0], c == 6); end
            end
            if (c == 7) begin
                n_checks++;
                if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got=%b exp=0", evt_valid); end
            end
            if (c == 8) begin
                n_checks++;
                if (evt_valid !== 1'b1 || evt_code !== 5'b01000) begin n_fail++; $display("FAIL single_press_evt got=%b/%b exp=1/01000", evt_valid, evt_code); end
                evt_rd = 1'b1;
            end
            if (c == 9) begin
                evt_rd = 1'b0;
                n_checks++;
                if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop got=%b exp=0", evt_valid); end
            end
            if (c == 10) btn_in[0] = 1'b0;
            if (c == 25) evt_rd = 1'b1;
        end
        evt_rd = 1'b0;
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 30; c++) begin
            btn_in[1] = (c < 20) ? (((c / 2) % 2) == 0) : 1'b0;
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL bounce_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
            n_checks++;
            if (btn_state[1] !== 1'b0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL bounce_quiet c=%0d state=%b valid=%b exp=0/0", c, btn_state[1], evt_valid); end
        end
    endtask

    task automatic test_long_press();
        logic [4:0] exp_codes [3];
        exp_codes[0] = 5'b01000;
        exp_codes[1] = 5'b11000;
        exp_codes[2] = 5'b10000;
        for (int c = 0; c < 55; c++) begin
            btn_in[0] = (c < 40);
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL long_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (evt_valid !== 1'b1 || evt_code !== exp_codes[j]) begin n_fail++; $display("FAIL long_order j=%0d got=%b/%b exp=1/%b", j, evt_valid, evt_code, exp_codes[j]); end
            evt_rd = 1'b1;
            step();
        end
        evt_rd = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL long_drained got=%b exp=0", evt_valid); end
    endtask

    task automatic test_simultaneous();
        btn_in = 2'b11;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) btn_in = 2'b00;
            evt_rd = (c == 9) || (c >= 30);
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL simul_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
            if (c == 8) begin
                n_checks++;
                if (evt_valid !== 1'b1 || evt_code !== 5'b01000) begin n_fail++; $display("FAIL simul_first got=%b/%b exp=1/01000", evt_valid, evt_code); end
            end
            if (c == 9) begin
                n_checks++;
                if (evt_valid !== 1'b1 || evt_code !== 5'b01001) begin n_fail++; $display("FAIL simul_second got=%b/%b exp=1/01001", evt_valid, evt_code); end
            end
        end
        evt_rd = 1'b0;
    endtask

    task automatic test_overflow();
        logic [NB-1:0] phase_pins [5];
        phase_pins[0] = 2'b11;
        phase_pins[1] = 2'b00;
        phase_pins[2] = 2'b01;
        phase_pins[3] = 2'b00;
        phase_pins[4] = 2'b01;
        for (int c = 0; c < 70; c++) begin
            btn_in = (c < 40) ? phase_pins[c / 8] : 2'b00;
            ovf_clr = (c == 41);
            evt_rd = (c >= 45);
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL ovf_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
            if (c == 23) begin
                n_checks++;
                if (overflow !== 1'b0 || evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_held_pending ovf=%b valid=%b exp=0/1", overflow, evt_valid); end
            end
            if (c == 39) begin
                n_checks++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_collision got=%b exp=1", overflow); end
            end
            if (c == 41) begin
                n_checks++;
                if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
            end
        end
        evt_rd = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        btn_in = 2'b10;
        for (int c = 0; c < 15; c++) begin
            if (c == 10) btn_in = 2'b11;
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL rstmid_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (btn_state !== '0 || evt_valid !== 1'b0 || evt_code !== 5'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs state=%b valid=%b code=%b ovf=%b exp=00/0/00000/0", btn_state, evt_valid, evt_code, overflow);
        end
        btn_in = 2'b01;
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            if (c == 10) btn_in = 2'b00;
            evt_rd = (c >= 24);
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL rstfresh_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
            if (c == 5 || c == 6) begin
                n_checks++;
                if (btn_state[0] !== (c == 6)) begin n_fail++; $display("FAIL rstfresh_latency c=%0d got=%b exp=%b", c, btn_state[0], c == 6); end
            end
        end
        evt_rd = 1'b0;
    endtask

    task automatic test_random();
        int dur [NB];
        for (int i = 0; i < NB; i++) dur[i] = 1;
        for (int c = 0; c < 1600; c++) begin
            for (int i = 0; i < NB; i++) begin
                dur[i]--;
                if (dur[i] <= 0) begin
                    btn_in[i] = ~btn_in[i];
                    dur[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 12));
                end
            end
            if (((c / 100) % 2) == 0)
                evt_rd = ($urandom_range(0, 9) < 6);
            else
                evt_rd = ($urandom_range(0, 19) == 0);
            ovf_clr = ($urandom_range(0, 49) == 0);
            step();
            n_checks++;
            if (btn_state !== m_state || evt_valid !== m_valid || overflow !== m_ovf || (m_valid && evt_code !== m_code)) begin
                n_fail++;
                $display("FAIL random_model t=%0d state=%b/%b valid=%b/%b code=%b/%b ovf=%b/%b", t, btn_state, m_state, evt_valid, m_valid, evt_code, m_code, overflow, m_ovf);
            end
        end
        evt_rd = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_long_press();
        test_simultaneous();
        test_overflow();
        test_reset_mid_debounce();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
